alu_core: RTL and testbench

Combinational 32-bit integer ALU for the single-cycle RV32I core, sitting in the execute stage between the operand muxes and the writeback mux. It computes add/sub, signed/unsigned set-less-than, bitwise logic, shifts and LUI pass-through, selected by a 4-bit opcode. A registered copy of the result is provided for debug and pipelining use.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_shifter.sv | 30 +++
 rtl/alu_core.sv | 72 +++++++
 tb/tb_alu_core.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding {funct7[5], funct3}, datapath widths, bit-reverse helper.
// Imported by alu_core, alu_shifter and the decoder that drives alu_op.
package alu_pkg;

   localparam int XLEN    = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SLL  = 4'h1,
      ALU_SLT  = 4'h2,
      ALU_SLTU = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SRL  = 4'h5,
      ALU_OR   = 4'h6,
      ALU_AND  = 4'h7,
      ALU_SUB  = 4'h8,
      ALU_LUI  = 4'hB,
      ALU_SRA  = 4'hD
   } alu_op_e;

   function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      r = '0;
      for (int i = 0; i < XLEN; i++) begin
         r[i] = v[XLEN-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// 5-stage logarithmic barrel shifter (SLL/SRL/SRA); purely combinational, zero latency, no backpressure.
// Left shifts reverse the word, shift right with zero fill, then reverse back.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [XLEN-1:0]    data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic               left_i,
   input  logic               arith_i,
   output logic [XLEN-1:0]    data_o
);

   logic [SHAMT_W:0][XLEN-1:0] stage;
   logic                       fill;

   // Sign fill only applies to arithmetic right shifts; the reversed left path always zero-fills.
   assign fill     = arith_i & ~left_i & data_i[XLEN-1];
   assign stage[0] = left_i ? bit_rev(data_i) : data_i;

   genvar k;
   generate
      for (k = 0; k < SHAMT_W; k++) begin : g_stage
         localparam int S = 2 ** k;
         assign stage[k+1] = shamt_i[k] ? {{S{fill}}, stage[k][XLEN-1:S]} : stage[k];
      end
   endgenerate

   assign data_o = left_i ? bit_rev(stage[SHAMT_W]) : stage[SHAMT_W];

endmodule

// File: rtl/alu_core.sv
// RV32I execute-stage ALU: combinational result (0 cycles) plus a 1-cycle registered copy.
// No handshake or backpressure; inputs may change every cycle.
module alu_core
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic [XLEN-1:0] alu_data,
   output logic [XLEN-1:0] alu_data_q
);

   logic            sub_en;
   logic [XLEN-1:0] b_op;
   logic [XLEN:0]   sum;
   logic            ovf;
   logic            slt;
   logic            sltu;
   logic [XLEN-1:0] shift_res;
   logic [XLEN-1:0] result_d;
   logic [XLEN-1:0] result_q;

   // One 33-bit adder serves ADD, SUB and both compares; compares run it as A - B.
   assign sub_en = alu_op[3] | (alu_op[2:1] == 2'b01);
   assign b_op   = sub_en ? ~operand_b : operand_b;
   assign sum    = {1'b0, operand_a} + {1'b0, b_op} + {{XLEN{1'b0}}, sub_en};

   assign ovf  = (operand_a[XLEN-1] ^ operand_b[XLEN-1]) & (sum[XLEN-1] ^ operand_a[XLEN-1]);
   assign slt  = sum[XLEN-1] ^ ovf;
   assign sltu = ~sum[XLEN];

   alu_shifter u_shifter (
      .data_i  (operand_a),
      .shamt_i (operand_b[SHAMT_W-1:0]),
      .left_i  (~alu_op[2]),
      .arith_i (alu_op[3]),
      .data_o  (shift_res)
   );

   always_comb begin
      result_d = '0;
      case (alu_op)
         ALU_ADD,
         ALU_SUB:  result_d = sum[XLEN-1:0];
         ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, slt};
         ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, sltu};
         ALU_XOR:  result_d = operand_a ^ operand_b;
         ALU_OR:   result_d = operand_a | operand_b;
         ALU_AND:  result_d = operand_a & operand_b;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  result_d = shift_res;
         ALU_LUI:  result_d = operand_b;
         default:  result_d = '0;
      endcase
   end

   assign alu_data = result_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign alu_data_q = result_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed and randomized checks of alu_core against hand-computed values and a behavioral model.
module tb_alu_core;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [3:0]  alu_op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [31:0] alu_data;
   logic [31:0] alu_data_q;

   int tests_run;
   int tests_failed;

   alu_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_op     (alu_op),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .alu_data   (alu_data),
      .alu_data_q (alu_data_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s: got %h, want %h", tag, observed, expected);
      end
   endtask

   task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_op    = op;
      operand_a = a;
      operand_b = b;
      #1;
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'h0: return a + b;
         4'h8: return a - b;
         4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h3: return (a < b) ? 32'd1 : 32'd0;
         4'h4: return a ^ b;
         4'h6: return a | b;
         4'h7: return a & b;
         4'h1: return a << b[4:0];
         4'h5: return a >> b[4:0];
         4'hD: return $unsigned($signed(a) >>> b[4:0]);
         4'hB: return b;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      alu_op       = 4'h0;
      operand_a    = 32'h0;
      operand_b    = 32'h0;
      #1;
      check("reset q", alu_data_q, 32'h0);
      @(posedge clk); #1;
      check("reset q held", alu_data_q, 32'h0);

      // Adder
      apply(ALU_ADD, 32'h7FFF_FFFF, 32'h1);          check("add ovf", alu_data, 32'h8000_0000);
      apply(ALU_SUB, 32'h0, 32'h1);                  check("sub wrap", alu_data, 32'hFFFF_FFFF);
      apply(ALU_ADD, 32'hFFFF_FFFF, 32'h1);          check("add carry", alu_data, 32'h0);
      apply(ALU_SUB, 32'h1234_5678, 32'h0234_5679);  check("sub mid", alu_data, 32'h0FFF_FFFF);

      // Compares
      apply(ALU_SLT,  32'hFFFF_FFFF, 32'h1);         check("slt neg", alu_data, 32'h1);
      apply(ALU_SLTU, 32'hFFFF_FFFF, 32'h1);         check("sltu big", alu_data, 32'h0);
      apply(ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF); check("slt ovf", alu_data, 32'h1);
      apply(ALU_SLT,  32'h7FFF_FFFF, 32'h8000_0000); check("slt ovf rev", alu_data, 32'h0);
      apply(ALU_SLTU, 32'h8000_0000, 32'h7FFF_FFFF); check("sltu msb", alu_data, 32'h0);
      apply(ALU_SLTU, 32'h1234_5678, 32'h1234_5678); check("sltu eq", alu_data, 32'h0);
      apply(ALU_SLT,  32'h1234_5678, 32'h1234_5678); check("slt eq", alu_data, 32'h0);
      apply(ALU_SLTU, 32'h1, 32'hFFFF_FFFF);         check("sltu lt", alu_data, 32'h1);

      // Shifts
      apply(ALU_SRL, 32'h8000_0000, 32'h0000_0024);  check("srl 4", alu_data, 32'h0800_0000);
      apply(ALU_SRA, 32'h8000_0000, 32'h0000_0024);  check("sra 4", alu_data, 32'hF800_0000);
      apply(ALU_SRA, 32'h7000_0000, 32'h0000_0004);  check("sra pos", alu_data, 32'h0700_0000);
      apply(ALU_SLL, 32'h0000_0001, 32'hFFFF_FFFF);  check("sll 31", alu_data, 32'h8000_0000);
      apply(ALU_SLL, 32'h8765_4321, 32'hFFFF_FFE0);  check("sll 0", alu_data, 32'h8765_4321);
      apply(ALU_SRL, 32'h8765_4321, 32'hFFFF_FFE0);  check("srl 0", alu_data, 32'h8765_4321);
      apply(ALU_SRA, 32'h8765_4321, 32'hFFFF_FFE0);  check("sra 0", alu_data, 32'h8765_4321);
      apply(ALU_SRA, 32'h8000_0001, 32'h0000_001F);  check("sra 31", alu_data, 32'hFFFF_FFFF);

      // Logic, pass-through, unused opcodes
      apply(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FF00);  check("xor", alu_data, 32'hFF00_ED34);
      apply(ALU_OR,  32'hF0F0_1234, 32'h0FF0_FF00);  check("or", alu_data, 32'hFFF0_FF34);
      apply(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);  check("and", alu_data, 32'h00F0_1200);
      apply(ALU_LUI, 32'hFFFF_FFFF, 32'h1234_5000);  check("lui", alu_data, 32'h1234_5000);
      apply(4'hE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);     check("op E", alu_data, 32'h0);
      apply(4'h9, 32'hFFFF_FFFF, 32'h1);             check("op 9", alu_data, 32'h0);
      apply(4'hA, 32'hFFFF_FFFF, 32'h1);             check("op A", alu_data, 32'h0);
      apply(4'hC, 32'hFFFF_FFFF, 32'h1);             check("op C", alu_data, 32'h0);
      apply(4'hF, 32'hFFFF_FFFF, 32'h1);             check("op F", alu_data, 32'h0);

      // Registered copy and asynchronous reset
      @(negedge clk);
      rst_n = 1'b1;
      apply(ALU_ADD, 32'd1, 32'd2);
      @(posedge clk); #1;
      check("q capture", alu_data_q, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("q async clr", alu_data_q, 32'h0);
      check("data in reset", alu_data, 32'd3);
      @(posedge clk); #1;
      check("q held in reset", alu_data_q, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("q before edge", alu_data_q, 32'h0);
      @(posedge clk); #1;
      check("q after release", alu_data_q, 32'd3);
      @(negedge clk);
      apply(ALU_SUB, 32'd10, 32'd4);
      @(posedge clk); #1;
      check("q follow", alu_data_q, 32'd6);

      // Randomized, every opcode value
      for (int op = 0; op < 16; op++) begin
         for (int n = 0; n < 100; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n == 0) rb = ra;
            apply(op[3:0], ra, rb);
            check($sformatf("rnd op%h a=%h b=%h", op[3:0], ra, rb), alu_data, model(op[3:0], ra, rb));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
